// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the
// multicycle core (c_*) and the program loader (l_*). Accesses are
// serialised through a four-state FSM (IDLE, ISSUE, WAIT, RESP) with
// round-robin fairness between the two requesters.
//
// Optional feature macro: MEM_ARB_LOCK_EN
//   When defined, l_lock lets the loader keep ownership for burst loading
//   once it has won a grant. When undefined, l_lock is ignored.
//
// Request handshake (both ports): a requester raises valid with we/addr/
// wdata stable; the access is accepted in the cycle where valid && ready
// are both 1. ready is combinational, only in IDLE, and only for the
// arbitration winner. Dropping valid before ready withdraws the request.
// Each accepted access is answered by exactly one single-cycle rvalid
// pulse on the owner's port (read data valid, or write done).
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  input  logic              l_lock,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;

  // WAIT lasts RD_LAT cycles; the counter reaches 0 on the cycle m_rdata is valid.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_owner;
  logic                r_last_grant;
  logic [1:0]          r_cnt;
  logic [31:0]         r_c_rdata;
  logic [31:0]         r_l_rdata;

  logic                w_idle;
  logic                w_lock_core;
  logic                w_grant_c;
  logic                w_grant_l;
  logic                w_sample;

  // Arbitration: single requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_lock_core = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    // Lock only holds off the core once the loader already owns last_grant.
    w_lock_core = l_lock && (r_last_grant == OWN_LDR);
`else
    // l_lock has no effect in this build.
    w_lock_core = l_lock & 1'b0;
`endif
    w_idle    = (r_state == S_IDLE);
    w_grant_c = w_idle && c_valid && !w_lock_core &&
                (!l_valid || (r_last_grant == OWN_LDR));
    w_grant_l = w_idle && l_valid &&
                (!c_valid || w_lock_core || (r_last_grant == OWN_CORE));
  end

  // Next-state and FSM-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    c_rvalid    = 1'b0;
    l_rvalid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_c || w_grant_l) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        m_en    = 1'b1;
        m_we    = r_we;
        m_addr  = r_addr;
        m_wdata = r_wdata;
        w_state_nxt = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_sample    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        c_rvalid    = (r_owner == OWN_CORE);
        l_rvalid    = (r_owner == OWN_LDR);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, request latch, read-latency counter and per-port read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner      <= OWN_CORE;
      r_last_grant <= OWN_LDR;
      r_cnt        <= 2'd0;
      r_c_rdata    <= '0;
      r_l_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_c) begin
        r_we         <= c_we;
        r_addr       <= c_addr;
        r_wdata      <= c_wdata;
        r_owner      <= OWN_CORE;
        r_last_grant <= OWN_CORE;
      end else if (w_grant_l) begin
        r_we         <= l_we;
        r_addr       <= l_addr;
        r_wdata      <= l_wdata;
        r_owner      <= OWN_LDR;
        r_last_grant <= OWN_LDR;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_sample) begin
        if (r_owner == OWN_CORE) r_c_rdata <= m_rdata;
        else                     r_l_rdata <= m_rdata;
      end
    end
  end

  assign c_ready     = w_grant_c;
  assign l_ready     = w_grant_l;
  assign c_rdata     = r_c_rdata;
  assign l_rdata     = r_l_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural memory of latency RD_LAT.
module tb_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              c_valid = 1'b0, c_we = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [31:0]       c_wdata = '0;
  logic              l_valid = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [31:0]       l_wdata = '0;
  logic              c_ready, c_rvalid, l_ready, l_rvalid;
  logic [31:0]       c_rdata, l_rdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_rdata;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_men    = 0;

  // Scoreboard entry: {loader_port, is_read, read_data}
  logic [33:0] exp_q[$];
  logic        hs_own_q[$];
  int          hs_cyc_q[$];

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_pipe [0:RD_LAT-1];

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_lock(l_lock),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] = m_wdata;
    rd_pipe[0] <= (m_en && !m_we) ? mem[m_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[RD_LAT-1];

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      if (m_en) n_men++;
      if (c_valid && c_ready) begin hs_own_q.push_back(1'b0); hs_cyc_q.push_back(cyc); end
      if (l_valid && l_ready) begin hs_own_q.push_back(1'b1); hs_cyc_q.push_back(cyc); end
      if (!m_en) begin
        n_checks++;
        if (m_we !== 1'b0 || m_addr !== '0 || m_wdata !== '0) begin
          n_fail++;
          $display("FAIL idle_bus: m_we=%b m_addr=%0h m_wdata=%0h, required all 0", m_we, m_addr, m_wdata);
        end
      end
      if (c_rvalid || l_rvalid) begin
        n_checks++;
        if (c_rvalid && l_rvalid) begin
          n_fail++;
          $display("FAIL sb_both_rvalid: c_rvalid=1 l_rvalid=1, required one");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: rvalid on port %0d with empty expected queue", l_rvalid);
        end else begin
          e = exp_q.pop_front();
          if (l_rvalid !== e[33]) begin
            n_fail++;
            $display("FAIL sb_port: response on port %0d, required port %0d", l_rvalid, e[33]);
          end else if (e[32] && ((l_rvalid ? l_rdata : c_rdata) !== e[31:0])) begin
            n_fail++;
            $display("FAIL sb_rdata: got %08h, required %08h", (l_rvalid ? l_rdata : c_rdata), e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n0;
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({c_ready, l_ready, c_rvalid, l_rvalid, m_en, m_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 000000", {c_ready, l_ready, c_rvalid, l_rvalid, m_en, m_we});
    end
    n_checks++;
    if (c_rdata !== 32'h0 || l_rdata !== 32'h0 || m_addr !== '0 || m_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: c_rdata=%0h l_rdata=%0h m_addr=%0h m_wdata=%0h, required 0", c_rdata, l_rdata, m_addr, m_wdata);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    n0 = n_men;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (n_men != n0) begin
      n_fail++;
      $display("FAIL idle_no_men: %0d strobes, required 0", n_men - n0);
    end
  endtask

  task automatic test_core_read();
    tick();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_wdata = 32'h0;
    exp_q.push_back({1'b0, 1'b1, 32'h0050_0093});
    @(negedge clk);
    n_checks++;
    if (c_ready !== 1'b1 || l_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL core_read_ready: c_ready=%b l_ready=%b, required 1 0", c_ready, l_ready);
    end
    tick();
    c_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 12'h010) begin
      n_fail++;
      $display("FAIL core_read_issue: m_en=%b m_we=%b m_addr=%0h, required 1 0 10", m_en, m_we, m_addr);
    end
    for (int i = 0; i < RD_LAT; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_en !== 1'b0 || c_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL core_read_wait: m_en=%b c_rvalid=%b, required 0 0", m_en, c_rvalid);
      end
    end
    @(negedge clk);
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'h0050_0093 || l_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL core_read_resp: c_rvalid=%b c_rdata=%08h l_rvalid=%b, required 1 00500093 0", c_rvalid, c_rdata, l_rvalid);
    end
    @(negedge clk);
    n_checks++;
    if (c_rvalid !== 1'b0 || c_rdata !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL core_read_hold: c_rvalid=%b c_rdata=%08h, required 0 00500093", c_rvalid, c_rdata);
    end
  endtask

  task automatic test_tie();
    int waited;
    apply_reset();
    hs_own_q.delete(); hs_cyc_q.delete();
    c_valid = 1'b1; c_we = 1'b1; c_addr = 12'h020; c_wdata = 32'hDEAD_BEEF;
    l_valid = 1'b1; l_we = 1'b1; l_addr = 12'h021; l_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'(i % 2), 1'b0, 32'h0});
    waited = 0;
    while (hs_own_q.size() < 4 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    tick();
    c_valid = 1'b0; l_valid = 1'b0;
    n_checks++;
    if (hs_own_q.size() != 4) begin
      n_fail++;
      $display("FAIL tie_count: %0d grants, required 4", hs_own_q.size());
    end
    for (int i = 0; i < hs_own_q.size() && i < 4; i++) begin
      n_checks++;
      if (hs_own_q[i] !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL tie_order: grant %0d to port %0d, required %0d", i, hs_own_q[i], i % 2);
      end
      if (i > 0) begin
        n_checks++;
        if (hs_cyc_q[i] - hs_cyc_q[i-1] != 3) begin
          n_fail++;
          $display("FAIL tie_spacing: gap %0d cycles, required 3", hs_cyc_q[i] - hs_cyc_q[i-1]);
        end
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (mem[12'h020] !== 32'hDEAD_BEEF || mem[12'h021] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL tie_mem: mem[20]=%08h mem[21]=%08h, required deadbeef 12345678", mem[12'h020], mem[12'h021]);
    end
  endtask

  task automatic test_withdraw();
    int n0;
    hs_own_q.delete(); hs_cyc_q.delete();
    n0 = n_men;
    tick();
    l_valid = 1'b1; l_we = 1'b0; l_addr = 12'h021;
    exp_q.push_back({1'b1, 1'b1, 32'h1234_5678});
    @(negedge clk);
    tick();
    l_valid = 1'b0;
    c_valid = 1'b1; c_we = 1'b0; c_addr = 12'h010;
    @(negedge clk);
    n_checks++;
    if (c_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_ready: c_ready=%b outside IDLE, required 0", c_ready);
    end
    tick();
    c_valid = 1'b0;
    repeat (RD_LAT + 4) @(negedge clk);
    #1;
    n_checks++;
    if (hs_own_q.size() != 1 || hs_own_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL withdraw_grants: %0d grants, required 1 (loader only)", hs_own_q.size());
    end
    n_checks++;
    if (n_men - n0 != 1) begin
      n_fail++;
      $display("FAIL withdraw_men: %0d strobes, required 1", n_men - n0);
    end
  endtask

  task automatic test_reset_mid_read();
    bit rv_seen;
    int waited;
    tick();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 12'h010;
    @(negedge clk);
    tick();
    c_valid = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_WAIT) begin
      n_fail++;
      $display("FAIL rst_mid_wait: state %0d, required %0d", dbg_state, ST_WAIT);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_IDLE || c_rdata !== 32'h0 || m_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: state=%0d c_rdata=%08h m_en=%b, required 0 0 0", dbg_state, c_rdata, m_en);
    end
    rv_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (c_rvalid || l_rvalid) rv_seen = 1'b1;
    end
    n_checks++;
    if (rv_seen) begin
      n_fail++;
      $display("FAIL rst_mid_no_rvalid: rvalid seen=1, required 0");
    end
    tick();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 12'h020;
    exp_q.push_back({1'b0, 1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    tick();
    c_valid = 1'b0;
    waited = 0;
    while (c_rvalid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rst_mid_recover: c_rvalid=%b c_rdata=%08h, required 1 deadbeef", c_rvalid, c_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    logic exp_g[$];
    int   k, ln, h4, hc, waited;
    bit   done, l_hs;
    // Core write alone so last_grant is core before the burst starts.
    tick();
    c_valid = 1'b1; c_we = 1'b1; c_addr = 12'h1FF; c_wdata = 32'hA5A5_A5A5;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    @(negedge clk);
    tick();
    c_valid = 1'b0;
    repeat (3) tick();
    hs_own_q.delete(); hs_cyc_q.delete();
`ifdef MEM_ARB_LOCK_EN
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    foreach (exp_g[i]) exp_q.push_back({exp_g[i], 1'b0, 32'h0});
    c_valid = 1'b1; c_we = 1'b1; c_addr = 12'h200; c_wdata = 32'hC0C0_0000;
    l_valid = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 12'h100; l_wdata = 32'h1000_0000;
    k = 0; ln = 0; h4 = -100; hc = -200; done = 1'b0; waited = 0;
    while (!done && waited < 80) begin
      @(negedge clk); #1;
      waited++;
      l_hs = 1'b0;
      while (k < hs_own_q.size()) begin
        if (hs_own_q[k]) begin
          ln++; l_hs = 1'b1;
          if (ln == 4) h4 = hs_cyc_q[k];
        end else if (ln == 4) begin
          hc = hs_cyc_q[k]; done = 1'b1;
        end
        k++;
      end
      tick();
      if (l_hs) begin
        if (ln >= 4) begin
          l_valid = 1'b0; l_lock = 1'b0;
        end else begin
          l_addr = 12'h100 + 12'(ln); l_wdata = 32'h1000_0000 + 32'(ln);
        end
      end
      if (done) c_valid = 1'b0;
    end
    c_valid = 1'b0; l_valid = 1'b0; l_lock = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL lock_timeout: burst not complete after %0d cycles", waited);
    end
    n_checks++;
    if (hs_own_q.size() != exp_g.size()) begin
      n_fail++;
      $display("FAIL lock_count: %0d grants, required %0d", hs_own_q.size(), exp_g.size());
    end
    for (int i = 0; i < hs_own_q.size() && i < exp_g.size(); i++) begin
      n_checks++;
      if (hs_own_q[i] !== exp_g[i]) begin
        n_fail++;
        $display("FAIL lock_order: grant %0d to port %0d, required %0d", i, hs_own_q[i], exp_g[i]);
      end
    end
    n_checks++;
    if (hc != h4 + 3) begin
      n_fail++;
      $display("FAIL lock_release: core granted at %0d, required %0d", hc, h4 + 3);
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[12'h100 + 12'(i)] !== 32'h1000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL lock_mem: mem[%0h]=%08h, required %08h", 12'h100 + 12'(i), mem[12'h100 + 12'(i)], 32'h1000_0000 + 32'(i));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mem[12'h010] = 32'h0050_0093;
    test_reset();
    test_core_read();
    test_tie();
    test_withdraw();
    test_reset_mid_read();
    test_lock();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
